// File: rtl/rag_csd_mem_pkg.sv
// Shared types and helpers for the weight-memory responder.
package rag_csd_mem_pkg;

    typedef enum logic [1:0] {MR_INIT, MR_READY} mem_resp_state_t;

    // Control half of a response travelling down the read pipeline.
    typedef struct packed {
        logic valid;
        logic err;
    } rd_resp_t;

    // Bytes per memory line for a given bus width in bits.
    function automatic int line_bytes(input int bus_width);
        return bus_width / 8;
    endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// Delay line for read responses: carries {valid, err, data} for STAGES cycles.
module rd_latency_pipe
    import rag_csd_mem_pkg::*;
#(
    parameter int W      = 512,
    parameter int STAGES = 1
)(
    input  logic           clk,
    input  logic           rst,
    input  rd_resp_t       resp_i,
    input  logic [W-1:0]   data_i,
    output rd_resp_t       resp_o,
    output logic [W-1:0]   data_o
);

    rd_resp_t     resp_q [STAGES];
    logic [W-1:0] data_q [STAGES];

    // Shift responses one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                resp_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            resp_q[0] <= resp_i;
            data_q[0] <= data_i;
            for (int i = 1; i < STAGES; i++) begin
                resp_q[i] <= resp_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign resp_o = resp_q[STAGES-1];
    assign data_o = data_q[STAGES-1];

endmodule

// File: rtl/weight_mem_responder.sv
// Responder for encoder weight reads: fixed-latency RAM lookup with address
// decode, zero-fill after reset, host load port and saturating counters.
module weight_mem_responder
    import rag_csd_mem_pkg::*;
#(
    parameter int          BUS_WIDTH   = 512,
    parameter int          DEPTH_LINES = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          RD_LATENCY  = 2      // must be >= 1
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mem_rd_en,
    input  logic [31:0]                    mem_rd_addr,
    output logic [BUS_WIDTH-1:0]           mem_rd_data,
    output logic                           mem_rd_valid,
    output logic                           mem_rd_err,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_LINES)-1:0] ld_line,
    input  logic [BUS_WIDTH-1:0]           ld_data,
    output logic                           init_busy,
    output logic [31:0]                    rd_count,
    output logic [15:0]                    err_count
);

    localparam int          LB     = line_bytes(BUS_WIDTH);
    localparam int          OFF_SH = $clog2(LB);
    localparam int          AW     = $clog2(DEPTH_LINES);
    localparam logic [32:0] SPAN   = 33'(DEPTH_LINES) * 33'(LB);

    mem_resp_state_t state_q;
    logic [AW-1:0]   init_line_q;
    logic            init_busy_q;

    logic [BUS_WIDTH-1:0] ram [DEPTH_LINES];
    logic                 ram_we;
    logic [AW-1:0]        ram_waddr;
    logic [BUS_WIDTH-1:0] ram_wdata;
    logic [BUS_WIDTH-1:0] ram_rd_q;

    logic [31:0]   rd_off;
    logic          rd_in_range;
    logic [AW-1:0] rd_line;

    rd_resp_t             s1_q;
    logic [BUS_WIDTH-1:0] s1_data;
    rd_resp_t             out_resp;
    logic [BUS_WIDTH-1:0] out_data;

    logic [31:0] rd_count_q, rd_count_d;
    logic [15:0] err_count_q, err_count_d;

    // Below-base addresses wrap to huge offsets and fall out of range.
    assign rd_off      = mem_rd_addr - BASE_ADDR;
    assign rd_in_range = {1'b0, rd_off} < SPAN;
    assign rd_line     = AW'(rd_off >> OFF_SH);

    // Lifecycle FSM: zero-fill one line per cycle, then serve forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MR_INIT;
            init_line_q <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                MR_INIT: begin
                    init_line_q <= init_line_q + AW'(1);
                    if (init_line_q == AW'(DEPTH_LINES - 1)) begin
                        state_q     <= MR_READY;
                        init_busy_q <= 1'b0;
                    end
                end
                MR_READY: ;
                default: begin
                    state_q     <= MR_INIT;
                    init_line_q <= '0;
                    init_busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Zero-fill owns the write port in INIT; host loads only land in READY.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ld_line;
        ram_wdata = ld_data;
        if (!rst) begin
            if (state_q == MR_INIT) begin
                ram_we    = 1'b1;
                ram_waddr = init_line_q;
                ram_wdata = '0;
            end else if (ld_en) begin
                ram_we    = 1'b1;
            end
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

    // RAM read port; reading in the same edge as a write yields the old line.
    always_ff @(posedge clk) begin
        ram_rd_q <= ram[rd_line];
    end

    // First response stage, aligned with the RAM read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
        end else begin
            s1_q.valid <= mem_rd_en;
            s1_q.err   <= mem_rd_en & ((state_q == MR_INIT) | ~rd_in_range);
        end
    end

    // Data is forced to zero for error responses and idle cycles.
    assign s1_data = (s1_q.valid && !s1_q.err) ? ram_rd_q : '0;

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign out_resp = s1_q;
            assign out_data = s1_data;
        end else begin : g_latn
            rd_latency_pipe #(
                .W      (BUS_WIDTH),
                .STAGES (RD_LATENCY - 1)
            ) u_pipe (
                .clk    (clk),
                .rst    (rst),
                .resp_i (s1_q),
                .data_i (s1_data),
                .resp_o (out_resp),
                .data_o (out_data)
            );
        end
    endgenerate

    // Saturating next-state for the request and error counters.
    always_comb begin
        rd_count_d  = rd_count_q;
        err_count_d = err_count_q;
        if (mem_rd_en && rd_count_q != 32'hFFFF_FFFF)
            rd_count_d = rd_count_q + 32'd1;
        if (out_resp.valid && out_resp.err && err_count_q != 16'hFFFF)
            err_count_d = err_count_q + 16'd1;
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            rd_count_q  <= rd_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign mem_rd_valid = out_resp.valid;
    assign mem_rd_err   = out_resp.err;
    assign mem_rd_data  = out_data;
    assign init_busy    = init_busy_q;
    assign rd_count     = rd_count_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_weight_mem_responder.sv
// Directed bench for weight_mem_responder (512-bit lines, 16 lines, latency 2).
module tb_weight_mem_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_rd_en;
    logic [31:0]  mem_rd_addr;
    logic [511:0] mem_rd_data;
    logic         mem_rd_valid;
    logic         mem_rd_err;
    logic         ld_en;
    logic [3:0]   ld_line;
    logic [511:0] ld_data;
    logic         init_busy;
    logic [31:0]  rd_count;
    logic [15:0]  err_count;

    typedef struct {
        int           due;
        logic         err;
        logic [511:0] data;
    } exp_t;

    exp_t expq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [511:0] pat_a = {16{32'hDEAD_BEEF}};
    logic [511:0] pat_x = {8{64'h0123_4567_89AB_CDEF}};

    weight_mem_responder #(
        .BUS_WIDTH   (512),
        .DEPTH_LINES (16),
        .BASE_ADDR   (BASE),
        .RD_LATENCY  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_err   (mem_rd_err),
        .ld_en        (ld_en),
        .ld_line      (ld_line),
        .ld_data      (ld_data),
        .init_busy    (init_busy),
        .rd_count     (rd_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one cycle and check the response port against the expected queue.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (expq.size() != 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            chk("rsp_valid", 512'(mem_rd_valid), 512'(1));
            chk("rsp_err",   512'(mem_rd_err),   512'(e.err));
            chk("rsp_data",  mem_rd_data,        e.data);
        end else begin
            chk("idle_valid", 512'(mem_rd_valid), 512'(0));
            chk("idle_err",   512'(mem_rd_err),   512'(0));
            chk("idle_data",  mem_rd_data,        512'(0));
        end
    endtask

    // Present one read for one cycle; its response is due two cycles later.
    task automatic rd_req(input logic [31:0] addr, input logic err, input logic [511:0] data);
        exp_t e;
        mem_rd_en   = 1'b1;
        mem_rd_addr = addr;
        e.due  = cyc + 2;
        e.err  = err;
        e.data = data;
        expq.push_back(e);
        step();
        mem_rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_rd_en = 1'b0; mem_rd_addr = '0;
        ld_en = 1'b0; ld_line = '0; ld_data = '0;

        // 1. Reset state, request during INIT, INIT length
        step();                                         // cycle 1
        chk("rst_busy",   512'(init_busy), 512'(1));
        chk("rst_rdcnt",  512'(rd_count),  512'(0));
        chk("rst_errcnt", 512'(err_count), 512'(0));
        rst = 1'b0;
        step(); step();                                 // cycle 3
        rd_req(BASE, 1'b1, '0);                         // response at cycle 5
        step(); step();                                 // cycle 6
        chk("init_errcnt", 512'(err_count), 512'(1));
        chk("init_rdcnt",  512'(rd_count),  512'(1));
        while (cyc < 16) step();
        chk("busy_c16", 512'(init_busy), 512'(1));
        step();
        chk("busy_c17", 512'(init_busy), 512'(0));

        // 2. Load line 3, read aligned and unaligned addresses within it
        ld_en = 1'b1; ld_line = 4'd3; ld_data = pat_a;
        step();
        ld_en = 1'b0;
        rd_req(BASE + 32'h0C0, 1'b0, pat_a);
        rd_req(BASE + 32'h0FF, 1'b0, pat_a);
        step(); step();

        // 3. Back-to-back reads of every line
        for (int i = 0; i < 16; i++)
            rd_req(BASE + 32'(i * 64), 1'b0, (i == 3) ? pat_a : 512'(0));
        step(); step();
        chk("b2b_rdcnt", 512'(rd_count), 512'(19));

        // 4. Out of range: one past the end, and below the base
        rd_req(32'h1000_0400, 1'b1, '0);
        rd_req(32'h0FFF_FFC0, 1'b1, '0);
        step(); step();
        chk("oor_errcnt", 512'(err_count), 512'(3));

        // 5. Read/load collision on line 5, then read after load
        ld_en = 1'b1; ld_line = 4'd5; ld_data = pat_x;
        rd_req(BASE + 32'h140, 1'b0, '0);
        ld_en = 1'b0;
        rd_req(BASE + 32'h140, 1'b0, pat_x);
        step(); step();

        // 6. Reset with requests in flight; loads ignored during INIT
        mem_rd_en = 1'b1; mem_rd_addr = BASE + 32'h0C0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; mem_rd_en = 1'b0;
        chk("mid_rdcnt",  512'(rd_count),  512'(0));
        chk("mid_errcnt", 512'(err_count), 512'(0));
        chk("mid_busy",   512'(init_busy), 512'(1));
        ld_en = 1'b1; ld_line = 4'd7; ld_data = pat_x;
        step();
        ld_en = 1'b0;
        for (int k = 0; k < 40 && init_busy; k++) step();
        chk("reinit_done", 512'(init_busy), 512'(0));
        rd_req(BASE + 32'h0C0, 1'b0, '0);
        rd_req(BASE + 32'h1C0, 1'b0, '0);
        rd_req(BASE + 32'h140, 1'b0, '0);
        step(); step();
        chk("final_rdcnt",  512'(rd_count),  512'(3));
        chk("final_errcnt", 512'(err_count), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
